// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: parity codes, FSM states
// and elaboration-time helpers for frame size and baud divider.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Total bit-times in one frame, start bit included.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  function automatic int baud_div(input int clk_hz, input int baud);
    return (baud > 0) ? (clk_hz / baud) : 0;
  endfunction

  function automatic int cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO holding queued characters. The head word is readable
// combinationally so the transmitter can pop and load its shifter on the same edge.
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [width-1:0]         push_data,
  input  logic                     pop,
  output logic [width-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   level
);

  localparam int AW = $clog2(depth);

  logic [width-1:0]  mem [depth];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       level_reg;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (level_reg == (AW+1)'(depth));
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign pop_data = mem[rd_ptr_reg];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok)      level_reg <= level_reg + 1'b1;
      else if (pop_ok && !push_ok) level_reg <= level_reg - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame format, fed by a small FIFO so a
// producer can burst characters; queued frames go out back-to-back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int clk_freq_hz = 0,
  parameter int baud_rate   = 57600,
  parameter int data_bits   = 8,
  parameter int parity      = 0,
  parameter int stop_bits   = 1,
  parameter int fifo_depth  = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [data_bits-1:0]            i_data,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic                            o_uart_tx,
  output logic                            o_busy,
  output logic [$clog2(fifo_depth):0]     o_level
);

  localparam int DIV = baud_div(clk_freq_hz, baud_rate);
  localparam int CW  = cnt_width(DIV);

  if (DIV < 4) begin : g_bad_div
    $error("uart_tx_fifo: clk_freq_hz/baud_rate must be at least 4");
  end
  if (data_bits < 5 || data_bits > 8) begin : g_bad_width
    $error("uart_tx_fifo: data_bits must be 5..8");
  end
  if (parity < PAR_NONE || parity > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_fifo: parity must be 0, 1 or 2");
  end
  if (stop_bits < 1 || stop_bits > 2) begin : g_bad_stop
    $error("uart_tx_fifo: stop_bits must be 1 or 2");
  end
  if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: fifo_depth must be a power of two >= 2");
  end

  tx_state_t              state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [2:0]             bit_reg, bit_next;
  logic [data_bits-1:0]   shift_reg, shift_next;
  logic                   par_reg, par_next;
  logic                   tx_reg, tx_next;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [data_bits-1:0]   head;
  logic                   par_load;
  logic                   tick;

  sync_fifo #(
    .width (data_bits),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (i_clk),
    .srst      (i_rst),
    .push      (i_valid),
    .push_data (i_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (o_level)
  );

  // Parity is taken from the word leaving the FIFO, not the one arriving.
  assign par_load = (parity == PAR_ODD) ? ~(^head) : (^head);
  assign tick     = (cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ST_START;
          cnt_next   = CW'(DIV - 1);
          bit_next   = '0;
          shift_next = head;
          par_next   = par_load;
        end
      end
      ST_START: begin
        cnt_next = tick ? CW'(DIV - 1) : cnt_reg - 1'b1;
        if (tick) begin
          state_next = ST_DATA;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        cnt_next = tick ? CW'(DIV - 1) : cnt_reg - 1'b1;
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == 3'(data_bits - 1)) begin
            state_next = (parity != PAR_NONE) ? ST_PARITY : ST_STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        cnt_next = tick ? CW'(DIV - 1) : cnt_reg - 1'b1;
        if (tick) begin
          state_next = ST_STOP;
          bit_next   = '0;
        end
      end
      ST_STOP: begin
        cnt_next = tick ? CW'(DIV - 1) : cnt_reg - 1'b1;
        if (tick) begin
          if (bit_reg == 3'(stop_bits - 1)) begin
            // Chain straight into the next start bit when more data is waiting.
            if (!empty) begin
              pop        = 1'b1;
              state_next = ST_START;
              bit_next   = '0;
              shift_next = head;
              par_next   = par_load;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = par_next;
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
    end
  end

  assign o_uart_tx = tx_reg;
  assign o_ready   = ~full;
  assign o_busy    = (state_reg != ST_IDLE) | (o_level != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: four transmitter instances (8N1, 8E1, 7O2, 8O1) at DIV=10;
// accepted words are queued and each decoded frame is checked bit-by-bit against them.
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 10;
  localparam int NI     = 4;
  localparam int GAPMAX = 400;
  localparam int ND [NI] = '{8, 8, 7, 8};
  localparam int PAR[NI] = '{0, 2, 1, 1};
  localparam int NS [NI] = '{1, 1, 2, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data  [NI];
  logic       valid [NI];
  logic       ready [NI];
  logic       tx    [NI];
  logic       busy  [NI];
  logic [2:0] level [NI];

  logic [7:0] sb[$];
  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    uart_tx_fifo #(
      .clk_freq_hz (CLK_HZ),
      .baud_rate   (BAUD),
      .data_bits   (ND[gi]),
      .parity      (PAR[gi]),
      .stop_bits   (NS[gi]),
      .fifo_depth  (4)
    ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_data    (data[gi][ND[gi]-1:0]),
      .i_valid   (valid[gi]),
      .o_ready   (ready[gi]),
      .o_uart_tx (tx[gi]),
      .o_busy    (busy[gi]),
      .o_level   (level[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive n words (base + i*37) with i_valid held; called on a negedge, returns on a negedge.
  task automatic producer(input int idx, input int n, input logic [7:0] base, input bit chk);
    int k;
    logic [7:0] w;
    valid[idx] = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = 8'(base + i * 37);
      if (ND[idx] == 7) w[7] = 1'b0;
      data[idx] = w;
      k = 0;
      while (ready[idx] !== 1'b1 && k < GAPMAX) begin
        @(negedge clk);
        k++;
      end
      if (k == GAPMAX) begin
        check("ready_timeout", 0, 1);
        break;
      end
      if (chk && k > 0) check("refill_level", 32'(level[idx]), 3);
      @(posedge clk);
      sb.push_back(w);
      $display("push i%0d word=%02h", idx, w);
      @(negedge clk);
      if (chk && i == 1) check("pushpop_level", 32'(level[idx]), 1);
      if (chk && i == 4) begin
        check("full_ready", 32'(ready[idx]), 0);
        check("full_level", 32'(level[idx]), 4);
      end
    end
    valid[idx] = 1'b0;
  endtask

  task automatic wait_start(input int idx, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (tx[idx] !== 1'b0 && gap < GAPMAX);
  endtask

  // Decode one frame; every sample of every bit-time must match the expected level.
  task automatic rx_frame(input int idx, input int gap_exp);
    int gap;
    int nb;
    logic [15:0] bits;
    logic [7:0] w;
    logic got_b;
    wait_start(idx, gap);
    check($sformatf("i%0d_start_gap", idx), gap, gap_exp);
    if (tx[idx] !== 1'b0) return;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    w = sb.pop_front();
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < ND[idx]; i++) bits[1+i] = w[i];
    nb = 1 + ND[idx];
    if (PAR[idx] != 0) begin
      bits[nb] = (PAR[idx] == 1) ? ~(^w) : (^w);
      nb++;
    end
    nb += NS[idx];
    for (int b = 0; b < nb; b++) begin
      got_b = bits[b];
      for (int j = 0; j < DIV; j++) begin
        if (!(b == 0 && j == 0)) @(negedge clk);
        if (tx[idx] !== bits[b] && got_b === bits[b]) got_b = tx[idx];
      end
      check($sformatf("i%0d_w%02h_bit%0d", idx, w, b), 32'(got_b), 32'(bits[b]));
    end
    $display("frame i%0d word=%02h bits=%0d", idx, w, nb);
  endtask

  task automatic single(input int idx, input logic [7:0] w);
    producer(idx, 1, w, 1'b0);
    check("pre_start_tx", 32'(tx[idx]), 1);
    check("pre_start_level", 32'(level[idx]), 1);
    check("pre_start_busy", 32'(busy[idx]), 1);
    rx_frame(idx, 1);
    check("last_stop_busy", 32'(busy[idx]), 1);
    @(negedge clk);
    check("after_frame_busy", 32'(busy[idx]), 0);
    check("after_frame_tx", 32'(tx[idx]), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bit seen_low;
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_tx%0d", i), 32'(tx[i]), 1);
      check($sformatf("rst_ready%0d", i), 32'(ready[i]), 1);
      check($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
      check($sformatf("rst_level%0d", i), 32'(level[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    single(0, 8'h55);
    single(1, 8'h55);
    single(3, 8'h55);
    single(2, 8'h41);

    // Six-word burst into a depth-4 FIFO: stall, refill and back-to-back frames.
    fork
      producer(0, 6, 8'h13, 1'b1);
      begin
        rx_frame(0, 2);
        for (int f = 0; f < 5; f++) rx_frame(0, 1);
      end
    join
    @(negedge clk);
    check("burst_idle_busy", 32'(busy[0]), 0);
    check("burst_sb_left", sb.size(), 0);

    // Reset in the middle of the second frame's data bits.
    fork
      producer(0, 4, 8'hC6, 1'b0);
      rx_frame(0, 2);
    join
    wait_start(0, g);
    check("f2_start_gap", g, 1);
    repeat (13) @(negedge clk);
    check("f2_level_before_rst", 32'(level[0]), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", 32'(tx[0]), 1);
    check("midrst_level", 32'(level[0]), 0);
    check("midrst_ready", 32'(ready[0]), 1);
    check("midrst_busy", 32'(busy[0]), 0);
    sb.delete();
    seen_low = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) seen_low = 1'b1;
    end
    check("no_restart", 32'(seen_low), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
